// File: rtl/bcd_display_scanner_pkg.sv
// Shared seven-segment definitions for the multiplexed BCD display scanner.
// Encodings are active-high in g f e d c b a order; drivers invert them for the panel.
package bcd_display_scanner_pkg;

    localparam int SEG_WIDTH = 7;

    // Bit position of each segment inside a segment vector.
    typedef enum int {
        SEG_BIT_A = 0,
        SEG_BIT_B = 1,
        SEG_BIT_C = 2,
        SEG_BIT_D = 3,
        SEG_BIT_E = 4,
        SEG_BIT_F = 5,
        SEG_BIT_G = 6
    } seg_bit_e;

    localparam logic [SEG_WIDTH-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_WIDTH-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_WIDTH-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_WIDTH-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_WIDTH-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_WIDTH-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_WIDTH-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_WIDTH-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_WIDTH-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_WIDTH-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_WIDTH-1:0] SEG_DASH  = 7'h40;
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble-to-segment decoder with blanking; active-low output.
// Non-decimal nibbles render as a dash so corrupt BCD is visible on the panel.
module bcd_to_7seg
    import bcd_display_scanner_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_segments
);

    logic [SEG_WIDTH-1:0] seg_on;

    always_comb begin
        // NOTE: every case arm assigns seg_on and a default covers the rest, so no latch is inferred.
        case (i_nibble)
            4'd0:    seg_on = SEG_0;
            4'd1:    seg_on = SEG_1;
            4'd2:    seg_on = SEG_2;
            4'd3:    seg_on = SEG_3;
            4'd4:    seg_on = SEG_4;
            4'd5:    seg_on = SEG_5;
            4'd6:    seg_on = SEG_6;
            4'd7:    seg_on = SEG_7;
            4'd8:    seg_on = SEG_8;
            4'd9:    seg_on = SEG_9;
            default: seg_on = SEG_DASH;
        endcase
    end

    assign o_segments = ~(i_blank ? SEG_BLANK : seg_on);

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed scanner for a common-anode BCD display with leading-zero blanking.
// New values are double-buffered and only swapped in at a frame boundary to avoid tearing.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int DECIMAL_DIGITS      = 2,
    parameter int CLKS_PER_DIGIT      = 25000,
    parameter int BLANK_LEADING_ZEROS = 1
) (
    input  logic                        i_Clock,
    input  logic                        i_Rst_L,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_DV,
    output logic [6:0]                  o_Segments,
    output logic [DECIMAL_DIGITS-1:0]   o_Anode,
    output logic                        o_Frame_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
    localparam int IDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam int BCD_W = DECIMAL_DIGITS * 4;

    logic [CNT_W-1:0]          counter_q, counter_d;
    logic [IDX_W-1:0]          index_q, index_d;
    logic [BCD_W-1:0]          shadow_q, shadow_d;
    logic [BCD_W-1:0]          display_q, display_d;
    logic                      pending_q, pending_d;
    logic [6:0]                segments_q, segments_d;
    logic [DECIMAL_DIGITS-1:0] anode_q, anode_d;

    logic                      terminal;
    logic                      frame_boundary;
    logic [DECIMAL_DIGITS-1:0] blank_vec;
    logic [3:0]                cur_nibble;
    logic                      cur_blank;

    assign terminal       = (counter_q == CNT_W'(CLKS_PER_DIGIT - 1));
    assign frame_boundary = terminal && (index_q == IDX_W'(DECIMAL_DIGITS - 1));

    always_comb begin
        counter_d = terminal ? '0 : counter_q + CNT_W'(1);
        index_d   = index_q;
        if (terminal) begin
            index_d = (index_q == IDX_W'(DECIMAL_DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
        end
    end

    // A strobe landing on the boundary bypasses the shadow so it is not held for a whole frame.
    always_comb begin
        shadow_d  = shadow_q;
        display_d = display_q;
        pending_d = pending_q;
        if (frame_boundary) begin
            if (i_DV) begin
                display_d = i_BCD;
            end else if (pending_q) begin
                display_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (i_DV) begin
            shadow_d  = i_BCD;
            pending_d = 1'b1;
        end
    end

    // Scan from the top digit down; a digit blanks only while everything above it is zero.
    always_comb begin
        logic zero_above;
        zero_above = (BLANK_LEADING_ZEROS != 0);
        blank_vec  = '0;
        for (int k = DECIMAL_DIGITS - 1; k > 0; k--) begin
            zero_above   = zero_above && (display_q[k*4 +: 4] == 4'd0);
            blank_vec[k] = zero_above;
        end
    end

    always_comb begin
        cur_nibble = '0;
        cur_blank  = 1'b0;
        anode_d    = '1;
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
            if (index_q == IDX_W'(k)) begin
                cur_nibble = display_q[k*4 +: 4];
                cur_blank  = blank_vec[k];
                anode_d[k] = 1'b0;
            end
        end
    end

    bcd_to_7seg u_decoder (
        .i_nibble   (cur_nibble),
        .i_blank    (cur_blank),
        .o_segments (segments_d)
    );

    always_ff @(posedge i_Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_Rst_L) begin
            counter_q  <= '0;
            index_q    <= '0;
            shadow_q   <= '0;
            display_q  <= '0;
            pending_q  <= 1'b0;
            segments_q <= ~SEG_BLANK;
            anode_q    <= '1;
        end else begin
            counter_q  <= counter_d;
            index_q    <= index_d;
            shadow_q   <= shadow_d;
            display_q  <= display_d;
            pending_q  <= pending_d;
            segments_q <= segments_d;
            anode_q    <= anode_d;
        end
    end

    assign o_Segments   = segments_q;
    assign o_Anode      = anode_q;
    assign o_Frame_Done = frame_boundary;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (2 digits, 4 clocks per digit).
// Stimulus pushes the value each frame should show; the monitor checks every scan sample.
module tb_bcd_display_scanner;

    localparam int DD    = 2;
    localparam int CPD   = 4;
    localparam int FRAME = DD * CPD;

    logic          clk;
    logic          rst_n;
    logic [7:0]    bcd;
    logic          dv;
    logic [6:0]    seg;
    logic [DD-1:0] anode;
    logic          frame_done;

    bcd_display_scanner #(
        .DECIMAL_DIGITS      (DD),
        .CLKS_PER_DIGIT      (CPD),
        .BLANK_LEADING_ZEROS (1)
    ) dut (
        .i_Clock      (clk),
        .i_Rst_L      (rst_n),
        .i_BCD        (bcd),
        .i_DV         (dv),
        .o_Segments   (seg),
        .o_Anode      (anode),
        .o_Frame_Done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Panel pattern (active-low) for a digit, from the display's decode rules.
    function automatic logic [6:0] exp_seg(input logic [3:0] n, input bit blank);
        if (blank) return 7'h7F;
        case (n)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Monitor: sample t is the t-th clock after reset release; it shows the previous cycle's scan slot.
    initial begin : monitor
        int         t;
        int         pop_at;
        int         sw_at;
        int         idx;
        logic [7:0] cur;
        logic [7:0] nxt;
        logic [3:0] digit;
        t = 0; pop_at = -1; sw_at = -1; cur = '0; nxt = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check("reset_segments", 32'(seg), 32'h7F);
                check("reset_anode", 32'(anode), 32'h3);
                check("reset_frame_done", 32'(frame_done), 32'h0);
                t = 0; pop_at = -1; sw_at = -1; cur = '0; nxt = '0;
            end else begin
                t++;
                if (t == pop_at) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL scoreboard_underflow: got empty queue expected an entry at %0t", $time);
                    end else begin
                        nxt = exp_q.pop_front();
                    end
                end
                if (t == sw_at) cur = nxt;
                idx   = ((t - 1) % FRAME) / CPD;
                digit = (idx == 1) ? cur[7:4] : cur[3:0];
                check("segments", 32'(seg), 32'(exp_seg(digit, (idx == 1) && (digit == 4'd0))));
                check("anode", 32'(anode), (idx == 1) ? 32'h1 : 32'h2);
                check("frame_done", 32'(frame_done), ((t % FRAME) == FRAME - 1) ? 32'h1 : 32'h0);
                if (frame_done) begin
                    pop_at = t + 1;
                    sw_at  = t + 2;
                end
            end
        end
    end

    // Stimulus-side reference: the value committed at each frame boundary is the last strobe seen
    // since the previous boundary (boundary cycle included), otherwise the value already shown.
    int         st;
    logic [7:0] pend;
    bit         have;
    logic [7:0] disp_m;

    task automatic cycle(input bit v, input logic [7:0] val);
        dv  = v;
        bcd = v ? val : 8'($urandom);
        if (v) begin
            pend = val;
            have = 1'b1;
        end
        if ((st % FRAME) == FRAME - 1) begin
            exp_q.push_back(have ? pend : disp_m);
            if (have) disp_m = pend;
            have = 1'b0;
        end
        @(posedge clk);
        #2;
        st++;
        dv = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic align(input int k);
        while ((st % FRAME) != k) cycle(1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        dv    = 1'b0;
        @(posedge clk);
        #2;
        rst_n  = 1'b1;
        st     = 0;
        have   = 1'b0;
        disp_m = '0;
    endtask

    initial begin : stimulus
        bit         v;
        logic [7:0] val;
        rst_n = 1'b0; dv = 1'b0; bcd = '0;
        st = 0; pend = '0; have = 1'b0; disp_m = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(12);

        align(2); cycle(1'b1, 8'h12); idle(20);
        align(3); cycle(1'b1, 8'h07); idle(20);
        align(0); cycle(1'b1, 8'h1A); idle(20);
        align(1); cycle(1'b1, 8'h34);
        align(4); cycle(1'b1, 8'h56); idle(20);
        align(FRAME - 1); cycle(1'b1, 8'h89); idle(20);
        align(FRAME - 1); cycle(1'b1, 8'h00); idle(20);

        align(2); cycle(1'b1, 8'h99);
        align(5); pulse_reset();
        idle(24);

        for (int i = 0; i < 600; i++) begin
            v      = ($urandom_range(0, 5) == 0);
            val[3:0] = 4'($urandom);
            val[7:4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            cycle(v, val);
        end
        idle(2 * FRAME + 3);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 Parameter DECIMAL_DIGITS, default 2: number of BCD digits accepted and scanned (1..8).
REQ-002 Parameter CLKS_PER_DIGIT, default 25000: clocks each digit stays lit per scan slot (>=2).
REQ-003 Parameter BLANK_LEADING_ZEROS, default 1: when 1, suppress leading zero digits.
REQ-004 i_Clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 i_Rst_L  in  1  reset, synchronous and active-low.
REQ-006 i_BCD  in  DECIMAL_DIGITS*4  packed BCD; digit 0 (least significant) in bits [3:0].
REQ-007 i_DV  in  1  one-cycle strobe; i_BCD is valid in that cycle (matches the converter's o_BCD/o_DV).
REQ-008 o_Segments  out  7  active-low segments, bit order g f e d c b a (bit6..bit0).
REQ-009 o_Anode  out  DECIMAL_DIGITS  active-low digit enables, one-hot-low when lit.
REQ-010 o_Frame_Done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-011 Slot counter SHALL count 0..CLKS_PER_DIGIT-1 and wrap; at terminal count the digit index SHALL advance, wrapping from DECIMAL_DIGITS-1 to 0.
REQ-012 Frame boundary = terminal count with index DECIMAL_DIGITS-1; o_Frame_Done SHALL be 1 in exactly that cycle.
REQ-013 On i_DV, i_BCD SHALL be captured into a shadow register and a pending flag set; a later i_DV before transfer SHALL overwrite the shadow (last wins).
REQ-014 At a frame boundary with pending set, shadow SHALL transfer to the display register and pending SHALL clear; without pending, the display register SHALL hold.
REQ-015 i_DV in a frame-boundary cycle: i_BCD SHALL load the display register directly, pending SHALL end cleared.
REQ-016 o_Segments/o_Anode SHALL be registered and reflect the index and display register of the previous cycle (1-cycle latency).
REQ-017 Decode (active-high gfedcba before inversion): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; nibbles A-F SHALL show dash (40).
REQ-018 Blanking: digit k blanked (o_Segments=7F) when BLANK_LEADING_ZEROS=1, k>0, and digits k..top are all 0; digit 0 is never blanked; a nibble >9 counts as nonzero.
REQ-019 A blanked digit SHALL keep its anode asserted (constant brightness timing).

Reset
REQ-020 With i_Rst_L=0 at a clock edge: counter=0, index=0, shadow=0, display=0, pending=0, o_Segments=7F, o_Anode=all 1s, o_Frame_Done=0.
REQ-021 Reset mid-scan or with pending set SHALL discard pending data; first output after release (one cycle later) is digit 0 showing '0' (o_Segments=40).

Structure
REQ-022 Shared package SHALL hold the segment encoding constants (digits 0-9, dash, blank) and the segment bit-order definition.
REQ-023 Combinational decoder SHALL be a sub-module bcd_to_7seg (nibble + blank in, 7 active-low segments out); counter, index, shadow/pending and blanking logic stay in bcd_display_scanner.

Verification (bench: DECIMAL_DIGITS=2, CLKS_PER_DIGIT=4)
REQ-024 i_BCD=8'h12 with i_DV pulse -> after next frame boundary, anode 2'b10 shows o_Segments=24, anode 2'b01 shows 79; o_Frame_Done every 8 clocks.
REQ-025 i_BCD=8'h07 -> digit0 o_Segments=78, digit1 o_Segments=7F with o_Anode=2'b01 still asserted in its slot.
REQ-026 i_BCD=8'h1A -> digit0 o_Segments=3F (dash), digit1 o_Segments=79.
REQ-027 Two i_DV in one frame (8'h34 then 8'h56) -> only 56 ever displayed; i_DV coincident with o_Frame_Done -> value shown from next frame.
REQ-028 i_Rst_L low for 1 clock mid-slot with pending set -> all outputs reset per REQ-020, pending value never shown, digit 0 shows 40.
